// File: rtl/mem_pkg.sv
// Shared types and helpers for the DRAM request controller.
// Line geometry, controller states and address mapping.
package mem_pkg;

  localparam int BLOCK_W         = 128;
  localparam int ADDR_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int LINE_SHIFT      = $clog2(WORDS_PER_BLOCK * 4);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } ctrl_state_t;

  // Byte address -> word index of the 16-byte line it falls in.
  function automatic logic [ADDR_W-1:0] line_to_word_adr(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] line;
    line = a >> LINE_SHIFT;
    return line << 2;
  endfunction

endpackage

// File: rtl/dram_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr with wrap; first set request wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  // Rotating priority search starting at ptr.
  always_comb begin : search
    logic found;
    int   k;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = PW'(k);
      end
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// Arbitrates cache line-fill / write-back requests onto DRAM.
// One transaction in flight, round-robin fairness, timeout.
module dram_ctrl
  import mem_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         req_valid,
  output logic [NUM_PORTS-1:0]         req_ready,
  input  logic [NUM_PORTS-1:0]         req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]  req_addr,
  input  logic [NUM_PORTS*BLOCK_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]         resp_valid,
  output logic                         resp_err,
  output logic [BLOCK_W-1:0]           resp_rdata,
  output logic                         MemWrite,
  output logic                         Valid,
  output logic [ADDR_W-1:0]            DataAdr,
  output logic [BLOCK_W-1:0]           WriteDataBlock,
  input  logic [BLOCK_W-1:0]           ReadDataBlock,
  input  logic                         Ready
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  ctrl_state_t state, state_n;

  logic [PW-1:0]        rr_ptr, rr_ptr_n;
  logic [PW-1:0]        port_q, port_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [NUM_PORTS-1:0] grant;
  logic [PW-1:0]        gidx;

  logic                 valid_n;
  logic                 memwrite_n;
  logic [ADDR_W-1:0]    adr_n;
  logic [BLOCK_W-1:0]   wdb_n;
  logic [NUM_PORTS-1:0] rvalid_n;
  logic                 rerr_n;
  logic [BLOCK_W-1:0]   rdata_n;

  rr_arbiter #(
    .N  (NUM_PORTS),
    .PW (PW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      port_q         <= '0;
      cnt            <= '0;
      Valid          <= 1'b0;
      MemWrite       <= 1'b0;
      DataAdr        <= '0;
      WriteDataBlock <= '0;
      resp_valid     <= '0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
    end else begin
      state          <= state_n;
      rr_ptr         <= rr_ptr_n;
      port_q         <= port_n;
      cnt            <= cnt_n;
      Valid          <= valid_n;
      MemWrite       <= memwrite_n;
      DataAdr        <= adr_n;
      WriteDataBlock <= wdb_n;
      resp_valid     <= rvalid_n;
      resp_err       <= rerr_n;
      resp_rdata     <= rdata_n;
    end
  end

  // Next state, next registered outputs, and req_ready.
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    port_n     = port_q;
    cnt_n      = cnt;
    valid_n    = 1'b0;
    memwrite_n = MemWrite;
    adr_n      = DataAdr;
    wdb_n      = WriteDataBlock;
    rvalid_n   = '0;
    rerr_n     = resp_err;
    rdata_n    = resp_rdata;
    req_ready  = '0;
    unique case (state)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          port_n     = gidx;
          memwrite_n = req_write[gidx];
          adr_n      = line_to_word_adr(
                         req_addr[ADDR_W*int'(gidx) +: ADDR_W]);
          wdb_n      = req_wdata[BLOCK_W*int'(gidx) +: BLOCK_W];
          valid_n    = 1'b1;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (Ready) begin
          if (!MemWrite) rdata_n = ReadDataBlock;
          rerr_n           = 1'b0;
          rvalid_n[port_q] = 1'b1;
          state_n          = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == CW'(TIMEOUT_CYCLES - 1)) begin
            rerr_n           = 1'b1;
            rvalid_n[port_q] = 1'b1;
            state_n          = RESP;
          end
        end
      end
      RESP: begin
        if (port_q == PW'(NUM_PORTS - 1)) rr_ptr_n = '0;
        else rr_ptr_n = port_q + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Scoreboard bench for dram_ctrl with a behavioural DRAM stub.
// Line-level reference memory predicts every response.
module tb_dram_ctrl;

  localparam int NP = 2;
  localparam int T  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0]     req_valid = '0;
  logic [NP-1:0]     req_ready;
  logic [NP-1:0]     req_write = '0;
  logic [NP*32-1:0]  req_addr = '0;
  logic [NP*128-1:0] req_wdata = '0;
  logic [NP-1:0]     resp_valid;
  logic              resp_err;
  logic [127:0]      resp_rdata;
  logic              MemWrite, Valid;
  logic [31:0]       DataAdr;
  logic [127:0]      WriteDataBlock, ReadDataBlock;
  logic              Ready;

  logic              stub_ready = 1'b0;
  logic [127:0]      rdb_stub = '0;
  logic              inj_ready = 1'b0;
  logic [127:0]      rdb_inj = '0;
  bit                withhold = 1'b0;

  assign Ready         = stub_ready | inj_ready;
  assign ReadDataBlock = inj_ready ? rdb_inj : rdb_stub;

  always #5 clk = ~clk;

  dram_ctrl #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata),
    .MemWrite(MemWrite), .Valid(Valid), .DataAdr(DataAdr),
    .WriteDataBlock(WriteDataBlock),
    .ReadDataBlock(ReadDataBlock), .Ready(Ready)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic fail_now(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // DRAM stub: word-addressed memory, Ready one cycle after Valid.
  logic [31:0] dmem [logic [31:0]];

  function automatic logic [31:0] dword(logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    stub_ready <= 1'b0;
    if (Valid) begin
      if (MemWrite) begin
        for (int k = 0; k < 4; k++)
          dmem[DataAdr + 32'(k)] = WriteDataBlock[32*k +: 32];
      end else begin
        rdb_stub <= {dword(DataAdr + 32'd3), dword(DataAdr + 32'd2),
                     dword(DataAdr + 32'd1), dword(DataAdr)};
      end
      stub_ready <= !withhold;
    end
  end

  // Reference model: 16-byte lines, resp_rdata shadow, rr pointer.
  logic [127:0] rline [logic [27:0]];
  logic [127:0] m_rdata = '0;
  int           mptr = 0;

  function automatic logic [127:0] ref_line(logic [27:0] l);
    return rline.exists(l) ? rline[l] : 128'h0;
  endfunction

  typedef struct {
    int           port;
    bit           err;
    logic [127:0] rdata;
    int           cyc;
  } exp_t;

  typedef struct {
    int           cyc;
    logic [31:0]  adr;
    bit           wr;
    logic [127:0] wd;
  } vexp_t;

  exp_t  exp_q[$];
  vexp_t vq[$];
  int    glog[$];
  int    alog[$];
  int    acc_count = 0;

  // Monitor: predicts on accept, checks Valid pulses and responses.
  always @(negedge clk) begin
    int           g, eg;
    logic [31:0]  a;
    logic [127:0] wd;
    bit           wr;
    exp_t         e;
    vexp_t        v;
    if (!reset) begin
      chk("ready_onehot", 128'($countones(req_ready) <= 1), 128'd1);
      if (Valid) begin
        if (vq.size() == 0) fail_now("stray_valid");
        else begin
          v = vq.pop_front();
          chk("valid_cycle", 128'(cyc), 128'(v.cyc));
          chk("data_adr", 128'(DataAdr), 128'(v.adr));
          chk("mem_write", 128'(MemWrite), 128'(v.wr));
          if (v.wr) chk("wdata_blk", WriteDataBlock, v.wd);
        end
      end
      if (resp_valid != '0) begin
        if (exp_q.size() == 0) fail_now("unexpected_resp");
        else begin
          e = exp_q.pop_front();
          chk("resp_port", 128'(resp_valid), 128'(1 << e.port));
          chk("resp_err", 128'(resp_err), 128'(e.err));
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
      if ((req_valid & req_ready) != '0) begin
        g = 0;
        for (int i = 0; i < NP; i++)
          if (req_valid[i] && req_ready[i]) g = i;
        eg = -1;
        for (int i = 0; i < NP; i++)
          if (eg < 0 && req_valid[(mptr + i) % NP]) eg = (mptr + i) % NP;
        chk("rr_grant", 128'(g), 128'(eg));
        mptr = (g + 1) % NP;
        a  = req_addr[32*g +: 32];
        wr = req_write[g];
        wd = req_wdata[128*g +: 128];
        if (wr) rline[a[31:4]] = wd;
        else if (!withhold) m_rdata = ref_line(a[31:4]);
        e.port  = g;
        e.err   = withhold;
        e.rdata = m_rdata;
        e.cyc   = cyc + (withhold ? T + 1 : 3);
        exp_q.push_back(e);
        v.cyc = cyc + 1;
        v.adr = (a >> 4) * 4;
        v.wr  = wr;
        v.wd  = wd;
        vq.push_back(v);
        glog.push_back(g);
        alog.push_back(cyc);
        acc_count++;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    req_valid = '0;
    exp_q.delete();
    vq.delete();
    m_rdata = '0;
    mptr = 0;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic set_port(int p, bit wr, logic [31:0] a,
                          logic [127:0] d);
    req_write[p]         = wr;
    req_addr[32*p +: 32]   = a;
    req_wdata[128*p +: 128] = d;
  endtask

  task automatic wait_accept(int maxc);
    int c0;
    bit got;
    c0 = acc_count;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      tick(1);
      if (acc_count != c0) got = 1'b1;
    end
    req_valid = '0;
    if (!got) fail_now("accept_timeout");
  endtask

  task automatic request(int p, bit wr, logic [31:0] a,
                         logic [127:0] d);
    set_port(p, wr, a, d);
    req_valid[p] = 1'b1;
    wait_accept(20);
  endtask

  task automatic drain(int maxc);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || vq.size() != 0) && i < maxc) begin
      tick(1);
      i++;
    end
    if (exp_q.size() != 0 || vq.size() != 0) fail_now("drain_timeout");
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_reset_vals(string tag);
    chk({tag, "_valid"}, 128'(Valid), 128'd0);
    chk({tag, "_memwrite"}, 128'(MemWrite), 128'd0);
    chk({tag, "_dataadr"}, 128'(DataAdr), 128'd0);
    chk({tag, "_wdb"}, WriteDataBlock, 128'd0);
    chk({tag, "_resp_valid"}, 128'(resp_valid), 128'd0);
    chk({tag, "_resp_err"}, 128'(resp_err), 128'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 128'd0);
  endtask

  localparam logic [127:0] LINE4 =
    128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [127:0] WBLK =
    128'h11111111_22222222_33333333_44444444;

  initial begin
    dmem[32'h10] = 32'hA;
    dmem[32'h11] = 32'hB;
    dmem[32'h12] = 32'hC;
    dmem[32'h13] = 32'hD;
    rline[28'h4] = LINE4;

    do_reset(3);
    @(negedge clk);
    check_reset_vals("rst");
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    tick(1);

    request(0, 1'b0, 32'h0000_0040, '0);
    drain(20);
    chk("t1_rdata", resp_rdata, LINE4);

    request(1, 1'b1, 32'h0000_0100, WBLK);
    drain(20);
    request(1, 1'b0, 32'h0000_0100, '0);
    drain(20);
    chk("t2_readback", resp_rdata, WBLK);

    do_reset(2);
    glog.delete();
    alog.delete();
    set_port(0, 1'b0, 32'h0000_0040, '0);
    set_port(1, 1'b0, 32'h0000_0100, '0);
    req_valid = 2'b11;
    for (int i = 0; i < 60 && glog.size() < 6; i++) tick(1);
    req_valid = '0;
    drain(20);
    if (glog.size() < 6) fail_now("fair_count");
    else begin
      for (int i = 0; i < 6; i++) begin
        chk("fair_order", 128'(glog[i]), 128'(i % 2));
        if (i > 0) chk("fair_gap", 128'(alog[i] - alog[i-1]), 128'd4);
      end
    end

    withhold = 1'b1;
    request(0, 1'b0, 32'h0000_0200, '0);
    drain(T + 10);
    chk("to_err_held", 128'(resp_err), 128'd1);
    withhold = 1'b0;
    rdb_inj = rnd128();
    inj_ready = 1'b1;
    tick(1);
    inj_ready = 1'b0;
    tick(6);
    chk("late_ready_rdata", resp_rdata, m_rdata);

    withhold = 1'b1;
    request(1, 1'b0, 32'h0000_0300, '0);
    tick(1);
    do_reset(1);
    withhold = 1'b0;
    rdb_inj = rnd128();
    inj_ready = 1'b1;
    set_port(0, 1'b0, 32'h0000_0040, '0);
    req_valid[0] = 1'b1;
    @(negedge clk);
    check_reset_vals("wrst");
    chk("wrst_accept", 128'(req_ready), 128'b01);
    tick(1);
    inj_ready = 1'b0;
    req_valid = '0;
    drain(20);

    rdb_inj = rnd128();
    inj_ready = 1'b1;
    tick(1);
    inj_ready = 1'b0;
    tick(3);
    chk("idle_ready_rdata", resp_rdata, LINE4);
    request(1, 1'b0, 32'h0000_0100, '0);
    drain(20);

    for (int t = 0; t < 40; t++) begin
      for (int p = 0; p < NP; p++)
        set_port(p, 1'($urandom % 2),
                 32'h1000 + 32'($urandom_range(0, 7) << 4)
                 + 32'($urandom % 16), rnd128());
      req_valid = NP'($urandom_range(1, 3));
      wait_accept(20);
      drain(20);
      tick($urandom_range(0, 3));
    end

    drain(40);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule
